switch_toggle_bank: RTL



---
 rtl/switch_toggle_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/switch_toggle_bank.sv
// rtl/switch_toggle_bank.sv - N-channel switch synchroniser, debouncer, edge detector and LED toggle bank
// Optional per-channel accepted-edge counter output o_Count when SWITCH_TOGGLE_BANK_COUNT_EN is defined.
module switch_toggle_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int EDGE_MODE      = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Edge_Pulse,
  output logic [NUM_CH-1:0] o_Debounced
`ifdef SWITCH_TOGGLE_BANK_COUNT_EN
  ,
  output logic [NUM_CH*8-1:0] o_Count
`endif
);

  localparam int              CW      = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("switch_toggle_bank: EDGE_MODE must be 0, 1 or 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("switch_toggle_bank: NUM_CH must be 1..16");
  end
  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("switch_toggle_bank: DEBOUNCE_LIMIT must be >= 2");
  end

  logic [NUM_CH-1:0] sync_1;
  logic [NUM_CH-1:0] sync_2;
  logic [NUM_CH-1:0] deb;
  logic [NUM_CH-1:0] deb_d;
  logic [NUM_CH-1:0] edge_hit;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] pulse_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= i_Switch;
      sync_2 <= sync_1;
    end
  end

  // Any sample matching the accepted level restarts the stability count.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          deb_q;

    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync_2[k] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= sync_2[k];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb[k] = deb_q;
  end

  if (EDGE_MODE == 0) begin : g_fall
    assign edge_hit = deb_d & ~deb;
  end else if (EDGE_MODE == 1) begin : g_rise
    assign edge_hit = ~deb_d & deb;
  end else begin : g_both
    assign edge_hit = deb_d ^ deb;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      deb_d   <= '0;
      pulse_q <= '0;
      led_q   <= '0;
    end else begin
      deb_d   <= deb;
      pulse_q <= edge_hit;
      led_q   <= led_q ^ edge_hit;
    end
  end

  assign o_LED        = led_q;
  assign o_Edge_Pulse = pulse_q;
  assign o_Debounced  = deb;

`ifdef SWITCH_TOGGLE_BANK_COUNT_EN
  // Counts advance on the same edge that raises the pulse; 8-bit wrap is intended.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    logic [7:0] edge_cnt_q;

    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        edge_cnt_q <= '0;
      end else if (edge_hit[k]) begin
        edge_cnt_q <= edge_cnt_q + 8'd1;
      end
    end

    assign o_Count[k*8 +: 8] = edge_cnt_q;
  end
`endif

endmodule
